// File: rtl/round_robin_mux.sv
// Forwards the word of the arbiter-selected queue downstream: pop at E0, read data at E1, push at E2.
// Optional macro MUX_PARITY_EN adds a registered even-parity bit alongside data_out.
module round_robin_mux #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  localparam int SW = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [SW-1:0]                       selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  input  logic                                out_almost_full,
  output logic [QUEUE_QUANTITY-1:0]           pop,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                push_out,
  output logic                                err_pop_empty
`ifdef MUX_PARITY_EN
  ,
  output logic                                data_out_parity
`endif
);

  logic                      sel_empty;
  logic [QUEUE_QUANTITY-1:0] sel_onehot;
  logic                      issue;
  logic                      bad_pop;
  logic [SW-1:0]             idx_s1, idx_s2;
  logic                      vld_s1, vld_s2;
  logic [DATA_BITS-1:0]      word;

  // An out-of-range selector matches no queue and is treated as empty.
  always_comb begin
    sel_empty  = 1'b1;
    sel_onehot = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (selector == SW'(i)) begin
        sel_empty     = buf_empty[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign issue   = enb & selector_enb & ~sel_empty & ~out_almost_full;
  assign bad_pop = selector_enb & sel_empty;

  always_comb begin
    word = '0;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (idx_s2 == SW'(i)) word = data_in[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop           <= '0;
      idx_s1        <= '0;
      idx_s2        <= '0;
      vld_s1        <= 1'b0;
      vld_s2        <= 1'b0;
      data_out      <= '0;
      push_out      <= 1'b0;
      err_pop_empty <= 1'b0;
    end else begin
      pop           <= issue ? sel_onehot : '0;
      idx_s1        <= issue ? selector : idx_s1;
      vld_s1        <= issue;
      idx_s2        <= idx_s1;
      vld_s2        <= vld_s1;
      push_out      <= vld_s2;
      err_pop_empty <= err_pop_empty | bad_pop;
      if (vld_s2) data_out <= word;
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         data_out_parity <= 1'b0;
    else if (vld_s2) data_out_parity <= ^word;
  end
`endif

endmodule

// File: tb/tb_round_robin_mux.sv
// Directed bench for round_robin_mux: inputs change 1ns after posedge, outputs checked at the same point.
module tb_round_robin_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  selector;
  logic        selector_enb;
  logic [3:0]  buf_empty;
  logic [31:0] data_in;
  logic        out_almost_full;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        push_out;
  logic        err_pop_empty;
`ifdef MUX_PARITY_EN
  logic        data_out_parity;
`endif

  int passed = 0;
  int total  = 0;

  round_robin_mux #(.QUEUE_QUANTITY(4), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .buf_empty(buf_empty), .data_in(data_in), .out_almost_full(out_almost_full),
    .pop(pop), .data_out(data_out), .push_out(push_out), .err_pop_empty(err_pop_empty)
`ifdef MUX_PARITY_EN
    , .data_out_parity(data_out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    total++; if (pop !== 4'b0000) $display("FAIL reset_pop: got %b want 0000", pop); else passed++;
    total++; if (push_out !== 1'b0) $display("FAIL reset_push: got %b want 0", push_out); else passed++;
    total++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else passed++;
    total++; if (err_pop_empty !== 1'b0) $display("FAIL reset_err: got %b want 0", err_pop_empty); else passed++;
  endtask

  // First edge after reset already issues.
  task automatic test_single;
    data_in = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    rst = 1'b0; selector = 2'd2; selector_enb = 1'b1;
    step();
    total++; if (pop !== 4'b0100) $display("FAIL single_pop: got %b want 0100", pop); else passed++;
    selector_enb = 1'b0;
    step();
    total++; if (pop !== 4'b0000) $display("FAIL single_pop_clear: got %b want 0000", pop); else passed++;
    total++; if (push_out !== 1'b0) $display("FAIL single_push_early: got %b want 0", push_out); else passed++;
    step();
    total++; if (push_out !== 1'b1) $display("FAIL single_push: got %b want 1", push_out); else passed++;
    total++; if (data_out !== 8'hA5) $display("FAIL single_data: got %h want a5", data_out); else passed++;
    step();
    total++; if (push_out !== 1'b0) $display("FAIL single_push_end: got %b want 0", push_out); else passed++;
    total++; if (data_out !== 8'hA5) $display("FAIL single_data_hold: got %h want a5", data_out); else passed++;
  endtask

  task automatic test_stream;
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 6; c++) begin
      selector = 2'(c % 4);
      selector_enb = (c < 4);
      step();
      total++;
      if (pop !== ((c < 4) ? (4'b0001 << c) : 4'b0000))
        $display("FAIL stream_pop[%0d]: got %b want %b", c, pop, (c < 4) ? (4'b0001 << c) : 4'b0000);
      else passed++;
      total++;
      if (push_out !== (c >= 2)) $display("FAIL stream_push[%0d]: got %b want %b", c, push_out, c >= 2);
      else passed++;
      if (c >= 2) begin
        total++;
        if (data_out !== 8'(8'h10 + c - 2))
          $display("FAIL stream_data[%0d]: got %h want %h", c, data_out, 8'(8'h10 + c - 2));
        else passed++;
      end
    end
    selector_enb = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    selector = 2'd1; selector_enb = 1'b1;
    step();
    total++; if (pop !== 4'b0010) $display("FAIL b2b_pop0: got %b want 0010", pop); else passed++;
    step();
    total++; if (pop !== 4'b0010) $display("FAIL b2b_pop1: got %b want 0010", pop); else passed++;
    selector_enb = 1'b0;
    step();
    total++; if (push_out !== 1'b1 || data_out !== 8'h22) $display("FAIL b2b_word0: got %b/%h want 1/22", push_out, data_out); else passed++;
    step();
    total++; if (push_out !== 1'b1 || data_out !== 8'h22) $display("FAIL b2b_word1: got %b/%h want 1/22", push_out, data_out); else passed++;
    step();
    total++; if (push_out !== 1'b0) $display("FAIL b2b_push_end: got %b want 0", push_out); else passed++;
  endtask

  // Backpressure at issue edges 3..5; in-flight words still drain.
  task automatic test_backpressure;
    bit iss [12];
    logic [7:0] last;
    logic [7:0] exp_d;
    last = 8'h00;
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 12; c++) begin
      out_almost_full = (c >= 3 && c <= 5);
      selector = 2'(c % 4);
      selector_enb = (c < 10);
      iss[c] = (c < 10) && !(c >= 3 && c <= 5);
      step();
      total++;
      if (pop !== (iss[c] ? (4'b0001 << (c % 4)) : 4'b0000))
        $display("FAIL bp_pop[%0d]: got %b want %b", c, pop, iss[c] ? (4'b0001 << (c % 4)) : 4'b0000);
      else passed++;
      if (c >= 2) begin
        total++;
        if (push_out !== iss[c-2]) $display("FAIL bp_push[%0d]: got %b want %b", c, push_out, iss[c-2]);
        else passed++;
        exp_d = iss[c-2] ? 8'(8'h10 + (c - 2) % 4) : last;
        total++;
        if (data_out !== exp_d) $display("FAIL bp_data[%0d]: got %h want %h", c, data_out, exp_d);
        else passed++;
        last = exp_d;
      end
    end
    out_almost_full = 1'b0;
    selector_enb = 1'b0;
  endtask

  task automatic test_enb_low;
    enb = 1'b0; selector = 2'd0; selector_enb = 1'b1;
    step();
    total++; if (pop !== 4'b0000) $display("FAIL enb_pop: got %b want 0000", pop); else passed++;
    total++; if (err_pop_empty !== 1'b0) $display("FAIL enb_err: got %b want 0", err_pop_empty); else passed++;
    selector_enb = 1'b0; enb = 1'b1;
    step();
    step();
    total++; if (push_out !== 1'b0) $display("FAIL enb_push: got %b want 0", push_out); else passed++;
  endtask

  task automatic test_pop_empty;
    buf_empty = 4'b0010; selector = 2'd1; selector_enb = 1'b1;
    step();
    total++; if (pop !== 4'b0000) $display("FAIL empty_pop: got %b want 0000", pop); else passed++;
    total++; if (err_pop_empty !== 1'b1) $display("FAIL empty_err: got %b want 1", err_pop_empty); else passed++;
    selector_enb = 1'b0; buf_empty = 4'b0000;
    step();
    step();
    total++; if (push_out !== 1'b0) $display("FAIL empty_push: got %b want 0", push_out); else passed++;
    total++; if (err_pop_empty !== 1'b1) $display("FAIL empty_err_sticky: got %b want 1", err_pop_empty); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (err_pop_empty !== 1'b0) $display("FAIL empty_err_clear: got %b want 0", err_pop_empty); else passed++;
  endtask

  task automatic test_reset_mid;
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    selector = 2'd3; selector_enb = 1'b1;
    step();
    total++; if (pop !== 4'b1000) $display("FAIL mid_pop: got %b want 1000", pop); else passed++;
    selector_enb = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (push_out !== 1'b0 || data_out !== 8'h00 || pop !== 4'b0000)
        $display("FAIL mid_flush[%0d]: got %b/%h/%b want 0/00/0000", c, push_out, data_out, pop);
      else passed++;
      step();
    end
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity;
    data_in = {8'h00, 8'h00, 8'h03, 8'h07};
    selector = 2'd0; selector_enb = 1'b1;
    step();
    selector = 2'd1;
    step();
    selector_enb = 1'b0;
    step();
    total++; if (data_out !== 8'h07 || data_out_parity !== 1'b1) $display("FAIL parity_07: got %h/%b want 07/1", data_out, data_out_parity); else passed++;
    step();
    total++; if (data_out !== 8'h03 || data_out_parity !== 1'b0) $display("FAIL parity_03: got %h/%b want 03/0", data_out, data_out_parity); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; enb = 1'b1; selector = 2'd0; selector_enb = 1'b0;
    buf_empty = 4'b0000; data_in = 32'h0; out_almost_full = 1'b0;
    #1;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_enb_low();
    test_pop_empty();
    test_reset_mid();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
